inert_seq: RTL and testbench

- Sequencer that drives the team's 16-bit SPI monarch to configure an inertial sensor, then services the sensor's data-ready interrupt.
- After power-up it waits a settling period and issues three configuration writes.
- It then reads the yaw-rate low and high bytes on each interrupt and presents a 16-bit yaw_rt with a one-cycle valid strobe.
- It sits between the SPI monarch (wrt/cmd/done/rd_data) and the heading/control logic.

---
 rtl/inert_seq.sv | 142 ++++++++++++++
 tb/tb_inert_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inert_seq.sv
// inert_seq: power-up configuration and yaw-rate readout sequencer for an
// inertial sensor, driving the 16-bit SPI monarch (wrt/cmd/done/rd_data).
module inert_seq #(
    parameter int TMR_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] yaw_rt,
    output logic        vld,
    output logic        init_cmplt
);

    localparam logic [2:0] SETTLE   = 3'd0;
    localparam logic [2:0] CFG1     = 3'd1;
    localparam logic [2:0] CFG2     = 3'd2;
    localparam logic [2:0] CFG3     = 3'd3;
    localparam logic [2:0] WAIT_INT = 3'd4;
    localparam logic [2:0] RD_YL    = 3'd5;
    localparam logic [2:0] RD_YH    = 3'd6;

    localparam logic [15:0] CMD_INT_EN = 16'h0D02;
    localparam logic [15:0] CMD_ACCEL  = 16'h1160;
    localparam logic [15:0] CMD_GYRO   = 16'h1450;
    localparam logic [15:0] CMD_RD_YL  = 16'hA600;
    localparam logic [15:0] CMD_RD_YH  = 16'hA700;

    logic [2:0]       state;
    logic [TMR_W-1:0] timer;
    logic             int_ff1;
    logic             int_ff2;
    logic             done_q;
    logic             cmplt;
    logic             unused_rd_hi;

    // The sensor returns one byte per read; the upper half of rd_data is don't-care.
    assign unused_rd_hi = ^rd_data[15:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ff1 <= 1'b0;
            int_ff2 <= 1'b0;
        end else begin
            int_ff1 <= INT;
            int_ff2 <= int_ff1;
        end
    end

    // Only a rising edge of done completes a transaction, so a done left high
    // from the previous transaction cannot satisfy the wait after a new wrt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done;
        end
    end

    assign cmplt = done & ~done_q;

    // Settle timer saturates at all ones and freezes once SETTLE is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if ((state == SETTLE) && !(&timer)) begin
            timer <= timer + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SETTLE;
            wrt        <= 1'b0;
            cmd        <= 16'h0000;
            yaw_rt     <= 16'h0000;
            vld        <= 1'b0;
            init_cmplt <= 1'b0;
        end else begin
            wrt <= 1'b0;
            vld <= 1'b0;
            case (state)
                SETTLE: begin
                    if (&timer) begin
                        wrt   <= 1'b1;
                        cmd   <= CMD_INT_EN;
                        state <= CFG1;
                    end
                end
                CFG1: begin
                    if (cmplt) begin
                        wrt   <= 1'b1;
                        cmd   <= CMD_ACCEL;
                        state <= CFG2;
                    end
                end
                CFG2: begin
                    if (cmplt) begin
                        wrt   <= 1'b1;
                        cmd   <= CMD_GYRO;
                        state <= CFG3;
                    end
                end
                CFG3: begin
                    if (cmplt) begin
                        init_cmplt <= 1'b1;
                        state      <= WAIT_INT;
                    end
                end
                WAIT_INT: begin
                    if (int_ff2) begin
                        wrt   <= 1'b1;
                        cmd   <= CMD_RD_YL;
                        state <= RD_YL;
                    end
                end
                RD_YL: begin
                    if (cmplt) begin
                        yaw_rt[7:0] <= rd_data[7:0];
                        wrt         <= 1'b1;
                        cmd         <= CMD_RD_YH;
                        state       <= RD_YH;
                    end
                end
                RD_YH: begin
                    if (cmplt) begin
                        yaw_rt[15:8] <= rd_data[7:0];
                        vld          <= 1'b1;
                        state        <= WAIT_INT;
                    end
                end
                default: begin
                    state <= SETTLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inert_seq.sv
// tb_inert_seq: randomized bench for inert_seq with an SPI responder and a
// transaction-level model of the expected command stream and yaw results.
module tb_inert_seq;

    localparam int TMR_W       = 4;
    localparam int SETTLE_CLKS = 1 << TMR_W;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        INT     = 1'b0;
    logic        done    = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt;
    logic [15:0] cmd;
    logic [15:0] yaw_rt;
    logic        vld;
    logic        init_cmplt;

    int num_checks = 0;
    int num_fails  = 0;

    int          n_cmd         = 0;
    int          n_vld         = 0;
    int          cyc           = 0;
    int          first_wrt_cyc = -1;
    bit          busy          = 1'b0;
    int          age           = 0;
    int          lat           = 0;
    int          drop_at       = 0;
    logic [15:0] cur_cmd       = 16'h0000;
    logic [7:0]  cur_lo        = 8'h00;
    logic [7:0]  cur_hi        = 8'h00;
    bit          vld_due       = 1'b0;
    bit          init_due      = 1'b0;
    bit          b2b_due       = 1'b0;
    logic [3:0]  int_hist      = 4'h0;
    logic [15:0] exp_yaw[$];
    logic [7:0]  byte_q[$];
    int          pairs;
    int          base;

    inert_seq #(.TMR_W(TMR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .INT        (INT),
        .done       (done),
        .rd_data    (rd_data),
        .wrt        (wrt),
        .cmd        (cmd),
        .yaw_rt     (yaw_rt),
        .vld        (vld),
        .init_cmplt (init_cmplt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic int_val);
        @(negedge clk);
        #1 INT = int_val;
    endtask

    task automatic waitCmds(input int target, input int budget);
        int k = 0;
        while (n_cmd < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_cmd < target) checkOutput("wait_cmds_timeout", n_cmd, target);
    endtask

    task automatic waitVld(input int target, input int budget);
        int k = 0;
        while (n_vld < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_vld < target) checkOutput("wait_vld_timeout", n_vld, target);
    endtask

    task automatic waitInit(input int budget);
        int k = 0;
        while (init_cmplt !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput("init_cmplt_reached", init_cmplt, 1);
    endtask

    // The sensor's view: three configuration writes, then read-low/read-high pairs.
    function automatic logic [15:0] expCmd(input int idx);
        if (idx == 0) return 16'h0D02;
        if (idx == 1) return 16'h1160;
        if (idx == 2) return 16'h1450;
        if (((idx - 3) % 2) == 0) return 16'hA600;
        return 16'hA700;
    endfunction

    function automatic logic [7:0] nextByte();
        if (byte_q.size() > 0) return byte_q.pop_front();
        return 8'($urandom);
    endfunction

    // SPI responder and scoreboard; done drops 0 or 1 clocks after wrt to exercise stale done.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_cmd         = 0;
            n_vld         = 0;
            cyc           = 0;
            first_wrt_cyc = -1;
            busy          = 1'b0;
            age           = 0;
            vld_due       = 1'b0;
            init_due      = 1'b0;
            b2b_due       = 1'b0;
            int_hist      = 4'h0;
            done          = 1'b0;
            exp_yaw.delete();
        end else begin
            cyc++;
            int_hist = {int_hist[2:0], INT};

            if (b2b_due) checkOutput("back_to_back_wrt", wrt, 1);
            b2b_due = 1'b0;

            if (vld || vld_due) begin
                checkOutput("vld_strobe", vld, vld_due);
                if (vld && vld_due) begin
                    if (exp_yaw.size() > 0) checkOutput("yaw_rt", yaw_rt, exp_yaw.pop_front());
                    n_vld++;
                    if (&int_hist) b2b_due = 1'b1;
                end
            end
            vld_due = 1'b0;

            if (init_due) checkOutput("init_cmplt_rise", init_cmplt, 1);
            init_due = 1'b0;

            if (wrt) begin
                checkOutput("wrt_while_busy", busy, 0);
                checkOutput("cmd_order", cmd, expCmd(n_cmd));
                checkOutput("init_vs_cmd", init_cmplt, (n_cmd >= 3));
                if (n_cmd == 0) first_wrt_cyc = cyc;
                n_cmd++;
                busy    = 1'b1;
                age     = 0;
                cur_cmd = cmd;
                lat     = $urandom_range(40, 4);
                drop_at = $urandom_range(1, 0);
                if (drop_at == 0) done = 1'b0;
            end else if (busy) begin
                age++;
                if (age == drop_at) done = 1'b0;
                if (age == lat) begin
                    checkOutput("cmd_hold", cmd, cur_cmd);
                    done = 1'b1;
                    busy = 1'b0;
                    if (cur_cmd == 16'hA600) begin
                        cur_lo  = nextByte();
                        rd_data = {8'($urandom), cur_lo};
                    end else if (cur_cmd == 16'hA700) begin
                        cur_hi  = nextByte();
                        rd_data = {8'($urandom), cur_hi};
                        exp_yaw.push_back({cur_hi, cur_lo});
                        vld_due = 1'b1;
                    end else begin
                        rd_data = 16'($urandom);
                        if (cur_cmd == 16'h1450) begin
                            checkOutput("init_cmplt_early", init_cmplt, 0);
                            init_due = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        byte_q.push_back(8'h34);
        byte_q.push_back(8'h12);
        byte_q.push_back(8'h56);
        byte_q.push_back(8'h78);
        byte_q.push_back(8'h9A);
        byte_q.push_back(8'hBC);

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_wrt", wrt, 0);
        checkOutput("rst_cmd", cmd, 16'h0000);
        checkOutput("rst_yaw_rt", yaw_rt, 16'h0000);
        checkOutput("rst_vld", vld, 0);
        checkOutput("rst_init_cmplt", init_cmplt, 0);
        #1 rst_n = 1'b1;

        // INT chatter during settle and configuration must not start reads.
        for (int k = 0; k < 600 && n_cmd < 3; k++) applyStimulus(1'($urandom));
        INT = 1'b0;
        waitCmds(3, 10);
        waitInit(200);
        repeat (20) @(negedge clk);
        checkOutput("first_wrt_cycle", first_wrt_cyc, SETTLE_CLKS);
        checkOutput("init_cmd_count", n_cmd, 3);

        applyStimulus(1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("int_to_wrt_early", wrt, 0);
        @(negedge clk);
        checkOutput("int_to_wrt", wrt, 1);
        #1 INT = 1'b0;
        waitVld(1, 200);
        repeat (80) @(negedge clk);
        checkOutput("single_pair_cmds", n_cmd, 5);
        checkOutput("single_pair_vld", n_vld, 1);

        pairs = $urandom_range(5, 3);
        applyStimulus(1'b1);
        waitVld(1 + pairs, 800);
        applyStimulus(1'b0);
        repeat (100) @(negedge clk);
        checkOutput("pair_parity", (n_cmd - 3) % 2, 0);
        checkOutput("vld_per_pair", n_vld, (n_cmd - 3) / 2);
        checkOutput("yaw_queue_drained", exp_yaw.size(), 0);

        // Reset while the high-byte read is outstanding.
        base = n_cmd;
        applyStimulus(1'b1);
        waitCmds(base + 2, 200);
        applyStimulus(1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_wrt", wrt, 0);
        checkOutput("midrst_cmd", cmd, 16'h0000);
        checkOutput("midrst_yaw_rt", yaw_rt, 16'h0000);
        checkOutput("midrst_vld", vld, 0);
        checkOutput("midrst_init_cmplt", init_cmplt, 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        waitCmds(1, 60);
        checkOutput("restart_wrt_cycle", first_wrt_cyc, SETTLE_CLKS);
        checkOutput("restart_cmd", cmd, 16'h0D02);
        waitInit(200);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

    initial begin
        #500000;
        num_checks++;
        num_fails++;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
